// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      VERIFY,
      DONE
   } loader_state_e;

   localparam int LOADER_DW      = 32;
   localparam int BYTES_PER_WORD = LOADER_DW / 8;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes them to instruction memory,
// reads the image back and compares checksums while holding the core.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = LOADER_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [DW-1:0] checksum,
   output logic          core_hold
);

   localparam int BPW = DW / 8;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

   loader_state_e state;
   logic [AW:0]   len_q;
   logic [AW:0]   idx;
   logic [AW:0]   rd_idx;
   logic [CW-1:0] byte_cnt;
   logic [DW-1:0] shreg;
   logic [DW-1:0] wsum;
   logic [DW-1:0] rsum;
   logic          rd_pend;
   logic          fin_pend;

   logic [DW-1:0] next_word;
   logic          byte_last;

   // New bytes enter at the top so the first byte ends up in bits [7:0].
   assign next_word = (shreg >> 8) | (DW'(in_data) << (DW - 8));
   assign byte_last = (byte_cnt == CW'(BPW - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         idx       <= '0;
         rd_idx    <= '0;
         byte_cnt  <= '0;
         shreg     <= '0;
         wsum      <= '0;
         rsum      <= '0;
         rd_pend   <= 1'b0;
         fin_pend  <= 1'b0;
         in_ready  <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         checksum  <= '0;
         core_hold <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  len_q    <= (len > MAX_LEN) ? MAX_LEN : len;
                  idx      <= '0;
                  rd_idx   <= '0;
                  byte_cnt <= '0;
                  wsum     <= '0;
                  rsum     <= '0;
                  rd_pend  <= 1'b0;
                  fin_pend <= 1'b0;
                  error    <= 1'b0;
                  if (len == '0) begin
                     checksum  <= '0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     core_hold <= 1'b0;
                     state     <= DONE;
                  end else begin
                     done      <= 1'b0;
                     busy      <= 1'b1;
                     core_hold <= 1'b1;
                     in_ready  <= 1'b1;
                     state     <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (in_valid && in_ready) begin
                  shreg    <= next_word;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_last) begin
                     byte_cnt  <= '0;
                     in_ready  <= 1'b0;
                     mem_wr    <= 1'b1;
                     mem_addr  <= idx[AW-1:0];
                     mem_wdata <= next_word;
                     state     <= WRITE;
                  end
               end
            end

            WRITE: begin
               mem_wr <= 1'b0;
               wsum   <= wsum + mem_wdata;
               idx    <= idx + 1'b1;
               if (idx + 1'b1 == len_q) begin
                  mem_addr <= '0;
                  state    <= VERIFY;
               end else begin
                  in_ready <= 1'b1;
                  state    <= LOAD;
               end
            end

            VERIFY: begin
               // Read data trails its address by one cycle, so summing is a stage behind issuing.
               if (rd_idx != len_q) begin
                  rd_idx  <= rd_idx + 1'b1;
                  rd_pend <= 1'b1;
                  if (rd_idx + 1'b1 != len_q) begin
                     mem_addr <= mem_addr + 1'b1;
                  end
               end else begin
                  rd_pend <= 1'b0;
               end
               if (rd_pend) begin
                  rsum <= rsum + mem_rdata;
                  if (rd_idx == len_q) begin
                     fin_pend <= 1'b1;
                  end
               end
               if (fin_pend) begin
                  fin_pend  <= 1'b0;
                  checksum  <= wsum;
                  error     <= (rsum != wsum);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  core_hold <= 1'b0;
                  state     <= DONE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with an inline synchronous SRAM responder
// and a word/checksum model derived from the transmitted byte stream.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  len;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_wr;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] checksum;
   logic        core_hold;

   int          checks;
   int          errors;
   int          cyc;
   int          c0;
   int          latency;
   bit          corrupt;
   bit          prevWr;
   logic [8:0]  lastWrAddr;
   logic [31:0] mem [512];
   logic [7:0]  stim [$];
   logic [31:0] expQ [$];
   logic [8:0]  expAddrQ [$];
   logic [31:0] modelSum;

   imem_loader #(.AW(9), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .checksum  (checksum),
      .core_hold (core_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory; corrupt flips bit 0 of word 1 on readback as a backdoor fault.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 9'd1) ? 32'h1 : 32'h0);
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s", name);
   endtask

   // Every write must match the next word the model predicts from the byte stream.
   always @(negedge clk) begin
      if (rst) begin
         prevWr = 1'b0;
      end else begin
         if (mem_wr) begin
            if (expQ.size() == 0) begin
               reportFail("unexpected mem_wr");
            end else begin
               checkOutput("wr addr", 64'(mem_addr), 64'(expAddrQ.pop_front()));
               checkOutput("wr data", 64'(mem_wdata), 64'(expQ.pop_front()));
            end
            checkOutput("in_ready during wr", 64'(in_ready), 64'd0);
            checkOutput("back-to-back wr", 64'(prevWr), 64'd0);
            lastWrAddr = mem_addr;
         end
         if (!busy) checkOutput("in_ready while not busy", 64'(in_ready), 64'd0);
         prevWr = mem_wr;
      end
   end

   task automatic buildModel(input int nWords);
      logic [31:0] w;
      expQ.delete();
      expAddrQ.delete();
      modelSum = 32'h0;
      for (int wi = 0; wi < nWords; wi++) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) w = w + (32'(stim[4*wi + k]) << (8*k));
         expQ.push_back(w);
         expAddrQ.push_back(9'(wi));
         modelSum = modelSum + w;
      end
   endtask

   task automatic startLoad(input int ln);
      @(negedge clk);
      start = 1'b1;
      len   = 10'(ln);
      @(negedge clk);
      start = 1'b0;
      c0    = cyc;
   endtask

   task automatic applyStimulus(input bit toggle);
      int i = 0;
      int guard = 0;
      bit phase = 1'b0;
      while (i < stim.size() && guard < 5000) begin
         in_valid = toggle ? phase : 1'b1;
         in_data  = stim[i];
         #4;
         if (in_valid && in_ready) i++;
         @(negedge clk);
         phase = !phase;
         guard++;
      end
      in_valid = 1'b0;
      if (i < stim.size()) reportFail("byte feed timeout");
   endtask

   task automatic waitDone(output int lat);
      int k = 0;
      while (!done && k < 4000) begin
         @(negedge clk);
         k++;
      end
      lat = cyc - c0;
      if (!done) reportFail("done timeout");
   endtask

   task automatic checkReset();
      checkOutput("rst in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst mem_wr", 64'(mem_wr), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst done", 64'(done), 64'd0);
      checkOutput("rst error", 64'(error), 64'd0);
      checkOutput("rst mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst mem_wdata", 64'(mem_wdata), 64'd0);
      checkOutput("rst checksum", 64'(checksum), 64'd0);
      checkOutput("rst core_hold", 64'(core_hold), 64'd1);
   endtask

   task automatic checkFinished(input string tag, input logic expErr);
      checkOutput({tag, " done"}, 64'(done), 64'd1);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " core_hold"}, 64'(core_hold), 64'd0);
      checkOutput({tag, " error"}, 64'(error), 64'(expErr));
      checkOutput({tag, " checksum"}, 64'(checksum), 64'(modelSum));
      checkOutput({tag, " pending writes"}, 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      corrupt  = 1'b0;
      prevWr   = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      len      = '0;
      in_valid = 1'b0;
      in_data  = '0;

      repeat (3) @(negedge clk);
      checkReset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle core_hold", 64'(core_hold), 64'd1);
      checkOutput("idle in_ready", 64'(in_ready), 64'd0);
      checkOutput("idle done", 64'(done), 64'd0);

      // Two-word program at full byte rate.
      stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      buildModel(2);
      checkOutput("model sum len2", 64'(modelSum), 64'h001000A6);
      checkOutput("model word1", 64'(expQ[1]), 64'h00100093);
      startLoad(2);
      checkOutput("busy after start", 64'(busy), 64'd1);
      applyStimulus(1'b0);
      waitDone(latency);
      checkFinished("len2", 1'b0);
      checkOutput("len2 checksum literal", 64'(checksum), 64'h001000A6);
      checkOutput("len2 done latency", 64'(latency), 64'd14);
      repeat (3) @(negedge clk);
      checkOutput("done sticky", 64'(done), 64'd1);

      // Zero-length load finishes straight away with no writes.
      stim.delete();
      buildModel(0);
      startLoad(0);
      checkFinished("len0", 1'b0);
      checkOutput("len0 checksum", 64'(checksum), 64'd0);
      repeat (3) @(negedge clk);

      // Throttled stream, three words.
      stim = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h01, 8'h02, 8'h03, 8'h04,
               8'hff, 8'hff, 8'hff, 8'hff};
      buildModel(3);
      checkOutput("model sum len3", 64'(modelSum), 64'hE2B0C0EF);
      startLoad(3);
      applyStimulus(1'b1);
      waitDone(latency);
      checkFinished("len3 toggled", 1'b0);

      // Corrupted readback of word 1.
      stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      buildModel(2);
      startLoad(2);
      applyStimulus(1'b0);
      corrupt = 1'b1;
      waitDone(latency);
      checkFinished("corrupt", 1'b1);
      corrupt = 1'b0;

      // Reset in the middle of a load discards the partial word.
      stim = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h11, 8'h22};
      buildModel(1);
      checkOutput("model partial word", 64'(expQ[0]), 64'hDDCCBBAA);
      startLoad(4);
      applyStimulus(1'b0);
      @(negedge clk);
      checkOutput("partial pending writes", 64'(expQ.size()), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkReset();
      rst = 1'b0;
      stim = '{8'h44, 8'h33, 8'h22, 8'h11};
      buildModel(1);
      startLoad(1);
      applyStimulus(1'b0);
      waitDone(latency);
      checkFinished("after rst len1", 1'b0);
      checkOutput("len1 checksum literal", 64'(checksum), 64'h11223344);
      checkOutput("len1 last addr", 64'(lastWrAddr), 64'd0);

      // Oversized length saturates to the full memory.
      stim.delete();
      for (int j = 0; j < 2048; j++) stim.push_back(8'((j * 37 + 5) & 255));
      buildModel(512);
      startLoad(600);
      applyStimulus(1'b0);
      waitDone(latency);
      checkFinished("len600", 1'b0);
      checkOutput("len600 last addr", 64'(lastWrAddr), 64'd511);
      checkOutput("len600 done latency", 64'(latency), 64'd3074);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
